// File: rtl/ps2_kbd_event_fifo.sv
// ps2_kbd_event_fifo: drains PS/2 scan bytes, folds E0/F0 prefixes into {ext,brk,code}
// events and buffers them in a first-word-fall-through FIFO for CPU polling.
module ps2_kbd_event_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            ps2_data,
    input  logic                  ps2_ready,
    output logic                  ps2_nextdata_n,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_ovf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;
    state_t state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic ext_q, ext_d, brk_q, brk_d, ovf_q, ovf_d;
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0] mem_q [DEPTH];
    logic is_ext, is_brk, is_err, push_req, push, pop, full;
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        full = count == (DEPTH_LOG2+1)'(DEPTH);
        is_ext = byte_q == 8'hE0;
        is_brk = byte_q == 8'hF0;
        is_err = byte_q == 8'h00 || byte_q == 8'hFF;
        push_req = state_q == ACK && !is_ext && !is_brk && !is_err;
        pop = rd_en && count != '0;
        // a full FIFO still accepts the event when the CPU frees a slot on the same edge
        push = push_req && (!full || pop);
        state_d = state_q == IDLE ? (ps2_ready ? ACK : IDLE) : state_q == ACK ? GAP : IDLE;
        byte_d = (state_q == IDLE && ps2_ready) ? ps2_data : byte_q;
        ext_d = state_q != ACK ? ext_q : is_ext ? 1'b1 : is_brk ? ext_q : 1'b0;
        brk_d = state_q != ACK ? brk_q : is_brk ? 1'b1 : is_ext ? brk_q : 1'b0;
        wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(push);
        rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(pop);
        ovf_d = (push_req && !push) || (ovf_q && !clr_ovf);
        rd_data = count == '0 ? 32'd0 : {22'd0, mem_q[rd_ptr_q[DEPTH_LOG2-1:0]]};
        ps2_nextdata_n = state_q != ACK;
        overflow = ovf_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q <= 8'd0;
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            ovf_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            byte_q <= byte_d;
            ext_q <= ext_d;
            brk_q <= brk_d;
            ovf_q <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {ext_q, brk_q, byte_q};
    end
endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
// tb_ps2_kbd_event_fifo: directed table vectors plus hand-written FIFO/handshake corner sequences.
module tb_ps2_kbd_event_fifo;
    logic clk = 1'b0, reset, ps2_ready, ps2_nextdata_n, rd_en, overflow, clr_ovf;
    logic [7:0] ps2_data;
    logic [31:0] rd_data;
    logic [3:0] count;
    int tests = 0, fails = 0, cyc = 0;

    ps2_kbd_event_fifo #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_nextdata_n(ps2_nextdata_n), .rd_en(rd_en), .rd_data(rd_data),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int n;
        logic [7:0] b [3];
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input string nm);
        int k = 0;
        while (ps2_nextdata_n !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) chk({nm, "_ack_timeout"}, 32'd1, 32'd0);
    endtask

    // keyboard model: present byte until the pop strobe is seen, optionally pop FIFO on the same edge
    task automatic send(input logic [7:0] b, input logic pop_too);
        ps2_data = b;
        ps2_ready = 1'b1;
        wait_ack("send");
        rd_en = pop_too;
        tick();
        rd_en = 1'b0;
        ps2_ready = 1'b0;
        chk("nextdata_single_low", {31'd0, ps2_nextdata_n}, 32'd1);
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] exp);
        chk(nm, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [6];
        int last;
        vecs[0] = '{1, '{8'h1C, 8'h00, 8'h00}, 32'h01C};
        vecs[1] = '{2, '{8'hF0, 8'h1C, 8'h00}, 32'h11C};
        vecs[2] = '{2, '{8'hE0, 8'h75, 8'h00}, 32'h275};
        vecs[3] = '{3, '{8'hE0, 8'hF0, 8'h75}, 32'h375};
        vecs[4] = '{3, '{8'hF0, 8'hE0, 8'h75}, 32'h375};
        vecs[5] = '{3, '{8'hE0, 8'h00, 8'h1C}, 32'h01C};
        vecs[6] = '{3, '{8'hF0, 8'hFF, 8'h22}, 32'h022};
        reset = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_nextdata_n", {31'd0, ps2_nextdata_n}, 32'd1);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send(vecs[i].b[j], 1'b0);
            chk($sformatf("vec%0d_count", i), {28'd0, count}, 32'd1);
            pop_chk($sformatf("vec%0d_data", i), vecs[i].exp);
            chk($sformatf("vec%0d_count_after", i), {28'd0, count}, 32'd0);
            chk($sformatf("vec%0d_empty_data", i), rd_data, 32'd0);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("pop_empty_count", {28'd0, count}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            send(8'h15 + 8'(i), 1'b0);
            if (i == 7) chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        end
        chk("full_count", {28'd0, count}, 32'd8);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_drain%0d", i), 32'h015 + 32'(i));
        chk("drained_empty", rd_data, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0);
        send(8'h2A, 1'b1);
        chk("pushpop_count", {28'd0, count}, 32'd8);
        chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 8; i++) pop_chk($sformatf("pushpop_drain%0d", i), 32'h030 + 32'(i));
        pop_chk("pushpop_tail", 32'h02A);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) send(8'h40 + 8'(r * 5 + i), 1'b0);
            chk($sformatf("wrap%0d_count", r), {28'd0, count}, 32'd5);
            for (int i = 0; i < 5; i++) pop_chk($sformatf("wrap%0d_%0d", r, i), 32'h040 + 32'(r * 5 + i));
        end

        send(8'hE0, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_count", {28'd0, count}, 32'd0);
        send(8'h6B, 1'b0);
        pop_chk("midrst_event", 32'h06B);

        seq = '{8'hE0, 8'h00, 8'h1C, 8'hF0, 8'hFF, 8'h22};
        last = 0;
        ps2_data = seq[0];
        ps2_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_ack("cont");
            if (i > 0) chk($sformatf("period%0d", i), 32'(cyc - last), 32'd3);
            last = cyc;
            tick();
            if (i < 5) ps2_data = seq[i + 1];
            else ps2_ready = 1'b0;
            chk($sformatf("cont_high%0d", i), {31'd0, ps2_nextdata_n}, 32'd1);
        end
        chk("cont_count", {28'd0, count}, 32'd2);
        pop_chk("cont_ev0", 32'h01C);
        pop_chk("cont_ev1", 32'h022);
        chk("cont_empty", rd_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
